// File: rtl/burst_pkg.sv
// Shared types and constants for the 64-bit, 4-beat burst memory interface.
package burst_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned BURST_BEATS = 4;
    localparam int unsigned BEAT_W      = 64;
    localparam int unsigned LINE_OFS_W  = 5;
    localparam int unsigned BEAT_CNT_W  = $clog2(BURST_BEATS);
    localparam int unsigned WAIT_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        GAP
    } burst_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } burst_op_t;

    typedef logic [BEAT_W-1:0]     beat_t;
    typedef logic [BEAT_CNT_W-1:0] beat_idx_t;

    localparam beat_idx_t LAST_BEAT = beat_idx_t'(BURST_BEATS - 1);

endpackage

// File: rtl/burst_mem_array.sv
// Single-port beat-wide backing store: synchronous write, registered read that
// returns zero whenever no read is requested.
module burst_mem_array
    import burst_pkg::*;
#(
    parameter int unsigned RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [RAM_AW-1:0] addr,
    input  beat_t             wdata,
    output beat_t             rdata
);

    localparam int unsigned DEPTH = 1 << RAM_AW;

    beat_t mem [DEPTH];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4-beat line burst interface: programmable
// request-to-data latency, one 256-bit line per request, sticky protocol error.
module burst_mem_responder
    import burst_pkg::*;
#(
    parameter int unsigned LATENCY = 8,
    parameter int unsigned IDX_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  beat_t             mem_wdata,
    output beat_t             mem_rdata,
    output logic              mem_resp,
    output logic              proto_err
);

    localparam int unsigned        RAM_AW    = IDX_W + BEAT_CNT_W;
    localparam logic [WAIT_W-1:0]  WAIT_LOAD = WAIT_W'(LATENCY - 1);

    burst_state_t       state;
    burst_op_t          op;
    logic [IDX_W-1:0]   idx;
    beat_idx_t          beat;
    logic [WAIT_W-1:0]  wait_cnt;

    logic               req_c;
    logic               ram_we_c;
    logic               ram_re_c;
    logic [RAM_AW-1:0]  ram_addr_c;
    logic               addr_unused_c;

    assign req_c         = mem_read | mem_write;
    assign addr_unused_c = ^{mem_address[ADDR_W-1:LINE_OFS_W+IDX_W],
                             mem_address[LINE_OFS_W-1:0]};

    // RAM control: reads are issued one cycle ahead so data lands with mem_resp.
    always_comb begin
        ram_addr_c = {idx, beat};
        ram_we_c   = 1'b0;
        ram_re_c   = 1'b0;
        unique case (state)
            WAIT: begin
                if (req_c && (wait_cnt == '0) && (op == OP_READ)) begin
                    ram_addr_c = {idx, beat_idx_t'(0)};
                    ram_re_c   = 1'b1;
                end
            end
            BURST: begin
                if (req_c) begin
                    if (op == OP_WRITE) begin
                        ram_we_c = 1'b1;
                    end else if (beat != LAST_BEAT) begin
                        ram_addr_c = {idx, beat_idx_t'(beat + beat_idx_t'(1))};
                        ram_re_c   = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Burst sequencing: IDLE -> WAIT -> BURST -> GAP -> IDLE, aborting on a dropped request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op        <= OP_READ;
            idx       <= '0;
            beat      <= '0;
            wait_cnt  <= '0;
            mem_resp  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_read && mem_write) begin
                        proto_err <= 1'b1;
                    end else if (mem_read ^ mem_write) begin
                        op       <= mem_write ? OP_WRITE : OP_READ;
                        idx      <= mem_address[LINE_OFS_W +: IDX_W];
                        wait_cnt <= WAIT_LOAD;
                        beat     <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!req_c) begin
                        proto_err <= 1'b1;
                        state     <= IDLE;
                    end else if (wait_cnt == '0) begin
                        beat     <= '0;
                        mem_resp <= 1'b1;
                        state    <= BURST;
                    end else begin
                        wait_cnt <= WAIT_W'(wait_cnt - 1'b1);
                    end
                end
                BURST: begin
                    if (!req_c) begin
                        proto_err <= 1'b1;
                        mem_resp  <= 1'b0;
                        beat      <= '0;
                        state     <= IDLE;
                    end else if (beat == LAST_BEAT) begin
                        mem_resp <= 1'b0;
                        beat     <= '0;
                        state    <= GAP;
                    end else begin
                        beat <= beat_idx_t'(beat + beat_idx_t'(1));
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    burst_mem_array #(
        .RAM_AW (RAM_AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_c),
        .re    (ram_re_c),
        .addr  (ram_addr_c),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

endmodule
